// File: rtl/coll_pkg.sv
// Shared types for the pairwise collision scheduler: object record, FSM states, defaults.
// Object records are 128 bits, laid out as x in the MSBs down to vy in the LSBs.
package coll_pkg;

  localparam int N_OBJ_DEF   = 8;
  localparam int TIMEOUT_DEF = 32;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] vx;
    logic [31:0] vy;
  } obj_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/coll_obj_table.sv
// Object table: one synchronous write port and two registered read ports.
// The read registers update only when i_rd_en is high, so the operands stay stable across a pair.
module coll_obj_table
  import coll_pkg::*;
#(
  parameter int N_OBJ = N_OBJ_DEF,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [127:0]     i_wdat,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_raddr_a,
  input  logic [IDX_W-1:0] i_raddr_b,
  output logic [127:0]     o_rd_a,
  output logic [127:0]     o_rd_b
);

  logic [127:0] r_mem [N_OBJ];
  logic [127:0] r_rd_a;
  logic [127:0] r_rd_b;

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else if (i_rd_en) begin
      r_rd_a <= r_mem[i_raddr_a];
      r_rd_b <= r_mem[i_raddr_b];
    end
  end

  assign o_rd_a = r_rd_a;
  assign o_rd_b = r_rd_b;

endmodule

// File: rtl/coll_pair_scheduler.sv
// Walks every unordered pair (i<j) of the object table through one shared collision detector.
// Each pair costs LOAD + ISSUE + detector wait + NEXT; the hit count, the first hit and the timeout flag are collected.
module coll_pair_scheduler
  import coll_pkg::*;
#(
  parameter int N_OBJ   = N_OBJ_DEF,
  parameter int IDX_W   = $clog2(N_OBJ),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_obj_we,
  input  logic [IDX_W-1:0]   i_obj_addr,
  input  logic [31:0]        i_obj_x,
  input  logic [31:0]        i_obj_y,
  input  logic [31:0]        i_obj_vx,
  input  logic [31:0]        i_obj_vy,
  input  logic [31:0]        i_r2,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_det_req,
  output logic [31:0]        o_det_x1,
  output logic [31:0]        o_det_y1,
  output logic [31:0]        o_det_vx1,
  output logic [31:0]        o_det_vy1,
  output logic [31:0]        o_det_x2,
  output logic [31:0]        o_det_y2,
  output logic [31:0]        o_det_vx2,
  output logic [31:0]        o_det_vy2,
  output logic [31:0]        o_det_r2,
  input  logic               i_det_done,
  input  logic               i_det_hit,
  output logic [2*IDX_W-1:0] o_hit_count,
  output logic               o_first_valid,
  output logic [IDX_W-1:0]   o_first_i,
  output logic [IDX_W-1:0]   o_first_j,
  output logic               o_err_timeout
);

  localparam int HC_W  = 2 * IDX_W;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [TMR_W-1:0]   r_timer;
  logic [31:0]        r_r2;
  logic [HC_W-1:0]    r_hit_count;
  logic               r_first_valid;
  logic [IDX_W-1:0]   r_first_i;
  logic [IDX_W-1:0]   r_first_j;
  logic               r_err_timeout;
  logic               w_busy;
  logic               w_done;
  logic               w_req;
  logic               w_rd_en;
  logic               w_tmo;
  logic               w_last;
  logic               w_tbl_we;
  obj_t               w_wdat;
  obj_t               w_obj_a;
  obj_t               w_obj_b;

  assign w_wdat   = '{x: i_obj_x, y: i_obj_y, vx: i_obj_vx, vy: i_obj_vy};
  assign w_tbl_we = i_obj_we && !w_busy;

  coll_obj_table #(
    .N_OBJ (N_OBJ),
    .IDX_W (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (w_tbl_we),
    .i_waddr   (i_obj_addr),
    .i_wdat    (w_wdat),
    .i_rd_en   (w_rd_en),
    .i_raddr_a (r_i),
    .i_raddr_b (r_j),
    .o_rd_a    (w_obj_a),
    .o_rd_b    (w_obj_b)
  );

  assign w_tmo  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last = (r_j == IDX_W'(N_OBJ - 1)) && (r_i == IDX_W'(N_OBJ - 2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs decode the state register, so a reset clears them without waiting for a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_req       = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = (N_OBJ < 2) ? DONE : LOAD;
      LOAD:  begin w_busy = 1'b1; w_rd_en = 1'b1; w_state_nxt = ISSUE; end
      ISSUE: begin w_busy = 1'b1; w_req = 1'b1; w_state_nxt = WAIT; end
      WAIT: begin
        w_busy = 1'b1;
        w_req  = 1'b1;
        if (i_det_done || w_tmo) w_state_nxt = NEXT;
      end
      NEXT:  begin w_busy = 1'b1; w_state_nxt = w_last ? DONE : LOAD; end
      DONE:  begin w_done = 1'b1; w_state_nxt = IDLE; end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r2          <= '0;
      r_hit_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_i     <= '0;
      r_first_j     <= '0;
      r_err_timeout <= 1'b0;
      r_i           <= '0;
      r_j           <= '0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_r2          <= i_r2;
          r_hit_count   <= '0;
          r_first_valid <= 1'b0;
          r_err_timeout <= 1'b0;
          r_i           <= '0;
          r_j           <= IDX_W'(1);
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          // A result in the expiry cycle still counts; only a silent detector flags a timeout.
          if (i_det_done) begin
            if (i_det_hit) begin
              if (r_hit_count != '1) r_hit_count <= r_hit_count + HC_W'(1);
              if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_i     <= r_i;
                r_first_j     <= r_j;
              end
            end
          end else if (w_tmo) begin
            r_err_timeout <= 1'b1;
          end
        end
        NEXT: begin
          if (r_j != IDX_W'(N_OBJ - 1)) begin
            r_j <= r_j + IDX_W'(1);
          end else if (r_i != IDX_W'(N_OBJ - 2)) begin
            r_i <= r_i + IDX_W'(1);
            r_j <= r_i + IDX_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_det_req     = w_req;
  assign o_det_x1      = w_obj_a.x;
  assign o_det_y1      = w_obj_a.y;
  assign o_det_vx1     = w_obj_a.vx;
  assign o_det_vy1     = w_obj_a.vy;
  assign o_det_x2      = w_obj_b.x;
  assign o_det_y2      = w_obj_b.y;
  assign o_det_vx2     = w_obj_b.vx;
  assign o_det_vy2     = w_obj_b.vy;
  assign o_det_r2      = r_r2;
  assign o_hit_count   = r_hit_count;
  assign o_first_valid = r_first_valid;
  assign o_first_i     = r_first_i;
  assign o_first_j     = r_first_j;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_coll_pair_scheduler.sv
// Bench for coll_pair_scheduler with N_OBJ=4: a behavioural detector plus a pair-list reference model.
module tb_coll_pair_scheduler;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int TMO   = 32;
  localparam int NPAIR = N * (N - 1) / 2;
  localparam int HCMAX = (1 << (2 * IW)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          obj_we = 1'b0;
  logic [IW-1:0] obj_addr = '0;
  logic [31:0]   obj_x = '0, obj_y = '0, obj_vx = '0, obj_vy = '0, r2 = '0;
  logic          start = 1'b0;
  logic          busy, done, det_req, det_done, det_hit;
  logic [31:0]   det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2, det_r2;
  logic [2*IW-1:0] hit_count;
  logic          first_valid, err_timeout;
  logic [IW-1:0] first_i, first_j;

  always #5 clk = ~clk;

  coll_pair_scheduler #(.N_OBJ(N), .IDX_W(IW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_obj_we(obj_we), .i_obj_addr(obj_addr),
    .i_obj_x(obj_x), .i_obj_y(obj_y), .i_obj_vx(obj_vx), .i_obj_vy(obj_vy),
    .i_r2(r2), .i_start(start), .o_busy(busy), .o_done(done), .o_det_req(det_req),
    .o_det_x1(det_x1), .o_det_y1(det_y1), .o_det_vx1(det_vx1), .o_det_vy1(det_vy1),
    .o_det_x2(det_x2), .o_det_y2(det_y2), .o_det_vx2(det_vx2), .o_det_vy2(det_vy2),
    .o_det_r2(det_r2), .i_det_done(det_done), .i_det_hit(det_hit),
    .o_hit_count(hit_count), .o_first_valid(first_valid), .o_first_i(first_i),
    .o_first_j(first_j), .o_err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_x[N], ref_y[N], ref_vx[N], ref_vy[N];
  bit  hit_cfg[N][N];
  bit  noans_cfg[N][N];
  int  lat_cfg[N][N];

  int          obs_i[$], obs_j[$], obs_len[$];
  logic [31:0] obs_r2[$];
  int          done_cnt = 0;
  logic        m_done = 1'b0, m_hit = 1'b0, inj_done = 1'b0, inj_hit = 1'b0;
  int          d_cnt = 0, d_pi = 0, d_pj = 0;
  bit          d_prev = 1'b0, d_hit = 1'b0;

  assign det_done = m_done | inj_done;
  assign det_hit  = m_done ? m_hit : inj_hit;

  function automatic int find_obj(logic [31:0] x, logic [31:0] y, logic [31:0] vx, logic [31:0] vy);
    for (int k = 0; k < N; k++)
      if (ref_x[k] == x && ref_y[k] == y && ref_vx[k] == vx && ref_vy[k] == vy) return k;
    return -1;
  endfunction

  // Detector: a new request is a rising det_req; it answers lat_cfg cycles later unless told to stay silent.
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (!rst_n) begin
      d_cnt  = 0;
      d_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (det_req && !d_prev) begin
        d_pi = find_obj(det_x1, det_y1, det_vx1, det_vy1);
        d_pj = find_obj(det_x2, det_y2, det_vx2, det_vy2);
        obs_i.push_back(d_pi);
        obs_j.push_back(d_pj);
        obs_len.push_back(1);
        obs_r2.push_back(det_r2);
        if (d_pi >= 0 && d_pj >= 0 && !noans_cfg[d_pi][d_pj]) begin
          d_cnt = lat_cfg[d_pi][d_pj];
          d_hit = hit_cfg[d_pi][d_pj];
        end else begin
          d_cnt = 0;
        end
      end else begin
        if (det_req) obs_len[obs_len.size()-1] = obs_len[obs_len.size()-1] + 1;
        if (d_cnt > 0) begin
          d_cnt--;
          if (d_cnt == 0) begin
            m_done = 1'b1;
            m_hit  = d_hit;
          end
        end
      end
      d_prev = det_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int k = 0; k < N; k++) begin
      ref_x[k] = $urandom; ref_y[k] = $urandom; ref_vx[k] = $urandom; ref_vy[k] = $urandom;
      obj_we = 1'b1; obj_addr = IW'(k);
      obj_x = ref_x[k]; obj_y = ref_y[k]; obj_vx = ref_vx[k]; obj_vy = ref_vy[k];
      tick();
    end
    obj_we = 1'b0;
  endtask

  task automatic set_cfg(input bit hit_all, input int lat);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        hit_cfg[a][b] = hit_all; noans_cfg[a][b] = 1'b0; lat_cfg[a][b] = lat;
      end
  endtask

  // Runs one sweep; edges counts clock edges from the one that samples start to the one that shows done.
  task automatic do_sweep(input logic [31:0] r2v, output int edges);
    start = 1'b1; r2 = r2v;
    tick();
    start = 1'b0; edges = 1;
    while (!done && edges < 3000) begin tick(); edges++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL sweep_done_bound done=%0b want 1 after %0d cycles", done, edges); end
    tick();
  endtask

  // Reference: walk the pairs in sweep order and apply the detector configuration.
  task automatic model_sweep(output int hc, output int fv, output int fi, output int fj, output int err, output int edges);
    hc = 0; fv = 0; fi = 0; fj = 0; err = 0; edges = 1;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        if (noans_cfg[a][b]) begin
          err = 1; edges += 3 + TMO;
        end else begin
          edges += 3 + lat_cfg[a][b];
          if (hit_cfg[a][b]) begin
            if (fv == 0) begin fv = 1; fi = a; fj = b; end
            if (hc < HCMAX) hc++;
          end
        end
      end
  endtask

  function automatic int order_errors(int base, logic [31:0] r2v);
    int bad = 0, k = 0;
    if (obs_i.size() - base != NPAIR) bad++;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        if (base + k < obs_i.size())
          if (obs_i[base+k] != a || obs_j[base+k] != b || obs_r2[base+k] !== r2v) bad++;
        k++;
      end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || det_req !== 1'b0) begin errors++; $display("FAIL reset_ctrl busy/done/req=%b%b%b want 000", busy, done, det_req); end
    @(negedge clk); rst_n = 1'b1; tick();
    checks++; if (hit_count !== '0 || first_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_result hc=%0d fv=%b err=%b want 0 0 0", hit_count, first_valid, err_timeout); end
    checks++; if (first_i !== '0 || first_j !== '0) begin errors++; $display("FAIL reset_first i=%0d j=%0d want 0 0", first_i, first_j); end
    checks++; if (det_x1 !== '0 || det_vy2 !== '0 || det_r2 !== '0) begin errors++; $display("FAIL reset_operands x1=%h vy2=%h r2=%h want 0", det_x1, det_vy2, det_r2); end
  endtask

  // mode 0: only (1,3) collides, latency 2; mode 1: every pair collides, latency 3.
  task automatic test_fixed_pattern(input int mode);
    int base, dbase, edges, lat, exp_hc, exp_fi, exp_fj;
    logic [31:0] r2v;
    lat = (mode == 0) ? 2 : 3;
    set_cfg(mode == 1, lat);
    if (mode == 0) hit_cfg[1][3] = 1'b1;
    exp_hc = (mode == 0) ? 1 : 6;
    exp_fi = (mode == 0) ? 1 : 0;
    exp_fj = (mode == 0) ? 3 : 1;
    base = obs_i.size(); dbase = done_cnt; r2v = $urandom;
    do_sweep(r2v, edges);
    checks++; if (order_errors(base, r2v) != 0) begin errors++; $display("FAIL fixed%0d_order bad=%0d want 0 (pairs seen %0d)", mode, order_errors(base, r2v), obs_i.size() - base); end
    checks++; if (hit_count !== 4'(exp_hc) || first_valid !== 1'b1) begin errors++; $display("FAIL fixed%0d_hits hc=%0d fv=%b want %0d 1", mode, hit_count, first_valid, exp_hc); end
    checks++; if (first_i !== 2'(exp_fi) || first_j !== 2'(exp_fj)) begin errors++; $display("FAIL fixed%0d_first got (%0d,%0d) want (%0d,%0d)", mode, first_i, first_j, exp_fi, exp_fj); end
    checks++; if (err_timeout !== 1'b0 || done_cnt - dbase != 1) begin errors++; $display("FAIL fixed%0d_status err=%b dones=%0d want 0 1", mode, err_timeout, done_cnt - dbase); end
    checks++; if (edges != NPAIR * (3 + lat) + 1) begin errors++; $display("FAIL fixed%0d_latency got %0d want %0d", mode, edges, NPAIR * (3 + lat) + 1); end
  endtask

  task automatic test_timeout();
    int base, edges;
    set_cfg(1'b1, 1);
    noans_cfg[0][2] = 1'b1;
    base = obs_i.size();
    do_sweep(32'h0000_1234, edges);
    checks++; if (order_errors(base, 32'h0000_1234) != 0) begin errors++; $display("FAIL timeout_order bad=%0d want 0", order_errors(base, 32'h0000_1234)); end
    checks++; if (obs_len.size() < base + 2 || obs_len[base+1] != TMO + 1 || obs_len[base] != 2) begin errors++; $display("FAIL timeout_req_len got %0d/%0d want 2/%0d", obs_len.size() > base ? obs_len[base] : -1, obs_len.size() > base + 1 ? obs_len[base+1] : -1, TMO + 1); end
    checks++; if (err_timeout !== 1'b1 || hit_count !== 4'd5) begin errors++; $display("FAIL timeout_result err=%b hc=%0d want 1 5", err_timeout, hit_count); end
    checks++; if (edges != 5 * 4 + (3 + TMO) + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", edges, 5 * 4 + (3 + TMO) + 1); end
  endtask

  task automatic test_random_sweeps();
    int base, edges, hc, fv, fi, fj, err, xedges;
    logic [31:0] r2v;
    for (int s = 0; s < 5; s++) begin
      if (s == 2) load_table();
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) begin
          hit_cfg[a][b] = 1'($urandom_range(0, 1));
          noans_cfg[a][b] = ($urandom_range(0, 7) == 0);
          lat_cfg[a][b] = $urandom_range(1, 4);
        end
      model_sweep(hc, fv, fi, fj, err, xedges);
      base = obs_i.size(); r2v = $urandom;
      do_sweep(r2v, edges);
      checks++; if (order_errors(base, r2v) != 0) begin errors++; $display("FAIL rand%0d_order bad=%0d want 0", s, order_errors(base, r2v)); end
      checks++; if (hit_count !== 4'(hc) || first_valid !== 1'(fv) || err_timeout !== 1'(err)) begin errors++; $display("FAIL rand%0d_result hc=%0d fv=%b err=%b want %0d %0d %0d", s, hit_count, first_valid, err_timeout, hc, fv, err); end
      if (fv == 1) begin
        checks++; if (first_i !== 2'(fi) || first_j !== 2'(fj)) begin errors++; $display("FAIL rand%0d_first got (%0d,%0d) want (%0d,%0d)", s, first_i, first_j, fi, fj); end
      end
      checks++; if (edges != xedges) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", s, edges, xedges); end
    end
  endtask

  task automatic test_busy_writes();
    int base, dbase, edges, base2;
    logic [31:0] r2v;
    set_cfg(1'b0, 2);
    base = obs_i.size(); dbase = done_cnt; r2v = 32'h0BAD_F00D;
    start = 1'b1; r2 = r2v;
    tick();
    start = 1'b0; r2 = ~r2v; edges = 1;
    while (!done && edges < 3000) begin
      obj_we = (edges % 5 == 1); obj_addr = IW'(edges % N);
      obj_x = 32'hDEAD; obj_y = $urandom; obj_vx = $urandom; obj_vy = $urandom;
      start = (edges % 7 == 3);
      tick(); edges++;
    end
    obj_we = 1'b0; start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done_bound done=%0b want 1", done); end
    repeat (6) tick();
    checks++; if (done_cnt - dbase != 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_single_done dones=%0d busy=%b want 1 0", done_cnt - dbase, busy); end
    checks++; if (order_errors(base, r2v) != 0) begin errors++; $display("FAIL busy_order bad=%0d want 0", order_errors(base, r2v)); end
    base2 = obs_i.size();
    do_sweep(32'h55, edges);
    checks++; if (order_errors(base2, 32'h55) != 0) begin errors++; $display("FAIL busy_table_kept bad=%0d want 0", order_errors(base2, 32'h55)); end
  endtask

  task automatic test_reset_mid();
    int base, dbase, n, edges;
    set_cfg(1'b0, 6);
    base = obs_i.size(); dbase = done_cnt;
    start = 1'b1; r2 = 32'h77;
    tick();
    start = 1'b0; n = 0;
    while (obs_i.size() - base < 3 && n < 500) begin tick(); n++; end
    checks++; if (obs_i.size() - base < 3) begin errors++; $display("FAIL rstmid_third_pair seen=%0d want 3", obs_i.size() - base); end
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (det_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async req=%b busy=%b want 0 0", det_req, busy); end
    checks++; if (det_x1 !== '0 || det_r2 !== '0) begin errors++; $display("FAIL rstmid_operands x1=%h r2=%h want 0", det_x1, det_r2); end
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (done_cnt != dbase) begin errors++; $display("FAIL rstmid_no_done dones=%0d want 0", done_cnt - dbase); end
    set_cfg(1'b0, 1);
    base = obs_i.size();
    do_sweep(32'h99, edges);
    checks++; if (order_errors(base, 32'h99) != 0) begin errors++; $display("FAIL rstmid_rerun bad=%0d want 0", order_errors(base, 32'h99)); end
  endtask

  task automatic test_idle_done();
    int edges;
    set_cfg(1'b0, 1);
    do_sweep(32'h1, edges);
    inj_hit = 1'b1; inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (2) tick();
    checks++; if (hit_count !== '0 || first_valid !== 1'b0) begin errors++; $display("FAIL idle_done hc=%0d fv=%b want 0 0", hit_count, first_valid); end
    checks++; if (busy !== 1'b0 || det_req !== 1'b0) begin errors++; $display("FAIL idle_done_state busy=%b req=%b want 0 0", busy, det_req); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    load_table();
    test_fixed_pattern(0);
    test_fixed_pattern(1);
    test_timeout();
    test_random_sweeps();
    test_busy_writes();
    test_reset_mid();
    test_idle_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
